audio_pdm_out: RTL and testbench
================================

# audio_pdm_out

Output stage of the audio path. It takes the unsigned samples that the volume amplifier produces and buffers them through a one-entry valid/ready holding register. A clock divider generates the sample-rate tick, and a first-order sigma-delta modulator drives a 1-bit PDM pin that feeds the board's RC low-pass filter. The block also detects and counts underruns; on an underrun it repeats the last sample.

## Interface
- `BITDEPTH`, default 14: sample width; matches the amplifier output.
- `CLKDIV`, default 1024: clocks per sample period; must be ≥ 2.
- `UNDERRUN_BITS`, default 8: width of the underrun counter.

- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  run the divider and modulator.
- `sample_in`  in  BITDEPTH  unsigned sample (midscale = silence).
- `sample_valid`  in  1  `sample_in` is valid.
- `sample_ready`  out  1  holding register can accept a sample.
- `sample_tick`  out  1  one-cycle pulse per sample period; upstream uses it as its request.
- `underrun_clr`  in  1  clear the underrun counter.
- `underrun_count`  out  UNDERRUN_BITS  saturating count of underruns.
- `pdm_out`  out  1  registered PDM bitstream.

## Operation
- **State:**
  - `hold` (BITDEPTH) and `hold_full`
  - `current` (BITDEPTH), the sample being modulated
  - `acc` (BITDEPTH)
  - `div` counter (0..CLKDIV-1)
  - `underrun_count`
  - `pdm_out`
- **Reset values:**
  - `hold_full`=0, `hold`=0
  - `current`=2^(BITDEPTH-1) (0x2000 at the default width)
  - `acc`=0, `div`=0, `underrun_count`=0, `pdm_out`=0
  - `sample_ready`=1 (sample_ready = !hold_full)
- **Handshake:** a transfer occurs when `sample_valid` && `sample_ready` on a clock edge. It is independent of `enable`.
- **Divider:**
  - When `enable` is high, `div` increments each cycle and wraps from CLKDIV-1 to 0.
  - `sample_tick` = `enable` && (`div` == CLKDIV-1), decoded combinationally from registered state.
  - When `enable` is low, `div` is held at 0.
- **On a tick cycle, in priority order:**
  - If `hold_full`: `current`←`hold`, `hold_full`←0. A new sample cannot be accepted in this cycle because `sample_ready` is 0.
  - Else if `sample_valid` (ready=1): bypass. `current`←`sample_in`, and `hold_full` stays 0. This is not an underrun.
  - Else: underrun. `current` is unchanged, and `underrun_count` saturates at 2^UNDERRUN_BITS-1.
- **Non-tick cycle:** an accepted sample goes to `hold`, and `hold_full`←1.
- **Underrun counter:** `underrun_clr` zeroes it, and the clear wins over a simultaneous increment.
- **Modulator (each cycle with `enable` high):**
  - sum = {1'b0,`acc`} + {1'b0,`current`}, giving BITDEPTH+1 bits.
  - `acc`←sum[BITDEPTH-1:0], `pdm_out`←sum[BITDEPTH].
  - The long-run ones density equals `current`/2^BITDEPTH. A value of 0 gives constant 0; the maximum value 2^BITDEPTH-1 gives a single 0 every 2^BITDEPTH cycles.
- **Disable:** `enable` low clears `acc` and `pdm_out` to 0 on the next edge. It keeps `current`, `hold`, and `hold_full`. The block resumes cleanly when `enable` rises again.
- **Reset mid-operation:** all state returns to the reset values immediately, and any held sample is discarded.

## Timing
- With `enable` rising at cycle 0 (`div`=0), the first tick is at cycle CLKDIV-1. Later ticks follow every CLKDIV cycles.
- A new `current` is loaded at the end of its tick cycle. The modulator uses it from the next cycle, so `pdm_out` reflects it one cycle after that (2 cycles after the tick).
- `sample_ready` falls the cycle after an accept. It rises the cycle after the tick that empties the hold.
- Upstream must present one sample per tick period. The single holding entry absorbs up to CLKDIV-1 cycles of early delivery.

## Test plan
- **Midscale:**
  - Stimulus: reset, `enable`=1, no samples; `current`=0x2000.
  - Required: `pdm_out` is 0 for the first edge, then alternates 1,0,1,0. Exactly 512 ones per 1024 cycles. `underrun_count` increments each tick.
- **Full-scale and zero:**
  - Stimulus: feed 0x3FFF, and after 16384 cycles measure ones.
  - Required: 16383 ones counted. Then feed 0x0000 and require `pdm_out` to be constant 0 from 2 cycles after the next tick.
- **Handshake:**
  - Stimulus: present 0x1234 with `valid` at `div`=100.
  - Required: accepted; `sample_ready` is 0 from `div`=101 until the cycle after the tick; `current`=0x1234 after the tick. A second sample offered during that window is not accepted.
- **Bypass:**
  - Stimulus: `hold` empty, `valid` asserted exactly on the tick cycle with 0x0ABC.
  - Required: `current`=0x0ABC next cycle, `hold_full` stays 0, no underrun.
- **Underrun counter:**
  - Stimulus: starve for 300 ticks.
  - Required: count saturates at 255. Asserting `underrun_clr` on a tick that also underruns yields 0.
- **Reset and disable:**
  - Stimulus: assert `rst` mid-period with `hold_full`=1.
  - Required: `pdm_out`=0, `sample_ready`=1, count=0, and `current` returns to 0x2000 immediately.
  - Stimulus: drop `enable` for 50 cycles.
  - Required: no ticks, `pdm_out`=0, and the `div` restart gives the first tick CLKDIV-1 cycles after re-enable.

Source files
------------

// File: rtl/audio_pdm_out.sv
// Audio output stage: one-entry sample hold, sample-rate tick divider and first-order sigma-delta PDM.
// A sample reaches pdm_out 2 cycles after its tick; sample_ready drops while the hold register is full.
module audio_pdm_out #(
  parameter int BITDEPTH      = 14,
  parameter int CLKDIV        = 1024,
  parameter int UNDERRUN_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [BITDEPTH-1:0]      sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  output logic                     sample_tick,
  input  logic                     underrun_clr,
  output logic [UNDERRUN_BITS-1:0] underrun_count,
  output logic                     pdm_out
);

  localparam int                     DIVW     = $clog2(CLKDIV);
  localparam logic [DIVW-1:0]        DIV_LAST = DIVW'(CLKDIV - 1);
  localparam logic [BITDEPTH-1:0]    MIDSCALE = {1'b1, {(BITDEPTH-1){1'b0}}};
  localparam logic [UNDERRUN_BITS-1:0] UND_MAX = '1;

  logic [DIVW-1:0]     div;
  logic [BITDEPTH-1:0] hold;
  logic                hold_full;
  logic [BITDEPTH-1:0] current;
  logic [BITDEPTH-1:0] acc;
  logic [BITDEPTH:0]   sum;
  logic                accept;
  logic                underrun;

  assign sample_ready = !hold_full;
  assign sample_tick  = enable && (div == DIV_LAST);
  assign accept       = sample_valid && sample_ready;
  assign underrun     = sample_tick && !hold_full && !sample_valid;
  assign sum          = {1'b0, acc} + {1'b0, current};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (!enable || sample_tick) begin
      div <= '0;
    end else begin
      div <= div + DIVW'(1);
    end
  end

  // On a tick the hold drains first; an empty hold lets a same-cycle sample bypass straight to current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      current   <= MIDSCALE;
    end else if (sample_tick) begin
      if (hold_full) begin
        current   <= hold;
        hold_full <= 1'b0;
      end else if (sample_valid) begin
        current <= sample_in;
      end
    end else if (accept) begin
      hold      <= sample_in;
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_count <= '0;
    end else if (underrun_clr) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != UND_MAX)) begin
      underrun_count <= underrun_count + UNDERRUN_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      pdm_out <= 1'b0;
    end else if (enable) begin
      acc     <= sum[BITDEPTH-1:0];
      pdm_out <= sum[BITDEPTH];
    end else begin
      acc     <= '0;
      pdm_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_pdm_out.sv
// Bench for audio_pdm_out: directed scenarios plus random traffic against a cycle-level reference model.
module tb_audio_pdm_out;

  localparam int BITDEPTH = 14;
  localparam int CLKDIV   = 16;
  localparam int UBITS    = 8;
  localparam int ONE      = 1 << BITDEPTH;
  localparam int UMAX     = (1 << UBITS) - 1;
  localparam int MID      = 1 << (BITDEPTH - 1);

  logic                clk;
  logic                rst;
  logic                enable;
  logic [BITDEPTH-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;
  logic                sample_tick;
  logic                underrun_clr;
  logic [UBITS-1:0]    underrun_count;
  logic                pdm_out;

  int checks = 0;
  int errors = 0;

  audio_pdm_out #(.BITDEPTH(BITDEPTH), .CLKDIV(CLKDIV), .UNDERRUN_BITS(UBITS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_tick(sample_tick),
    .underrun_clr(underrun_clr), .underrun_count(underrun_count), .pdm_out(pdm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: state as it stands after the most recent clock edge.
  int m_cur, m_acc, m_pdm, m_und, m_run;
  int m_hold[$];

  task automatic m_reset();
    m_cur = MID; m_acc = 0; m_pdm = 0; m_und = 0; m_run = 0;
    m_hold.delete();
  endtask

  task automatic m_step();
    bit tk;
    bit und;
    int s;
    tk  = enable && ((m_run % CLKDIV) == CLKDIV - 1);
    und = 1'b0;
    if (enable) begin
      s = m_acc + m_cur;
      m_pdm = (s >= ONE) ? 1 : 0;
      m_acc = s % ONE;
    end else begin
      m_acc = 0; m_pdm = 0;
    end
    if (tk) begin
      if (m_hold.size() > 0) m_cur = m_hold.pop_front();
      else if (sample_valid) m_cur = int'(sample_in);
      else und = 1'b1;
    end else if (sample_valid && m_hold.size() == 0) begin
      m_hold.push_back(int'(sample_in));
    end
    if (underrun_clr) m_und = 0;
    else if (und && m_und < UMAX) m_und++;
    m_run = enable ? m_run + 1 : 0;
  endtask

  always @(negedge clk) begin
    if (rst) m_reset();
    chk("ready", sample_ready, (m_hold.size() == 0) ? 1 : 0);
    chk("tick", sample_tick, (enable && ((m_run % CLKDIV) == CLKDIV - 1)) ? 1 : 0);
    chk("pdm", pdm_out, m_pdm);
    chk("underrun_count", underrun_count, m_und);
    if (!rst) m_step();
  end

  task automatic tick_wait();
    int n;
    n = 0;
    @(negedge clk);
    while (!sample_tick && n < 4 * CLKDIV) begin
      @(negedge clk);
      n++;
    end
    if (!sample_tick) chk("tick_timeout", 0, 1);
  endtask

  // Leaves the bench just after the edge that starts the cycle with divider phase d.
  task automatic goto_div(int d);
    tick_wait();
    repeat (d + 1) @(posedge clk);
    #1;
  endtask

  task automatic offer(logic [BITDEPTH-1:0] v);
    sample_in = v; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    int ones;
    int idx;
    rst = 1'b0; enable = 1'b0; sample_in = '0; sample_valid = 1'b0; underrun_clr = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", sample_ready, 1);
    chk("rst_pdm", pdm_out, 0);
    chk("rst_count", underrun_count, 0);
    chk("rst_current", dut.current, MID);

    // Midscale with no samples: alternating bitstream and one underrun per tick.
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("mid_seq", pdm_out, (k % 2 == 0) ? 1 : 0);
    end
    ones = 0;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      ones += int'(pdm_out);
    end
    chk("mid_ones", ones, 512);
    chk("mid_underruns", underrun_count, 64);

    // Full scale gives exactly one zero per 2^BITDEPTH cycles.
    goto_div(3);
    offer(14'h3FFF);
    tick_wait();
    @(negedge clk);
    chk("fs_current", dut.current, 16'h3FFF);
    ones = 0;
    for (int k = 0; k < ONE; k++) begin
      @(negedge clk);
      ones += int'(pdm_out);
    end
    chk("fs_ones", ones, ONE - 1);

    goto_div(3);
    offer(14'h0000);
    tick_wait();
    @(negedge clk);
    ones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ones += int'(pdm_out);
    end
    chk("zero_ones", ones, 0);

    // Handshake: accept at phase 5, ready stays low through the tick, second offer is ignored.
    goto_div(5);
    sample_in = 14'h1234; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_in = 14'h0555;
    for (int k = 0; k < CLKDIV - 6; k++) begin
      @(negedge clk);
      chk("hs_ready_low", sample_ready, 0);
    end
    chk("hs_tick", sample_tick, 1);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(negedge clk);
    chk("hs_ready_back", sample_ready, 1);
    chk("hs_current", dut.current, 16'h1234);

    // Bypass on the tick cycle with an empty hold.
    goto_div(CLKDIV - 2);
    underrun_clr = 1'b1;
    @(posedge clk); #1;
    underrun_clr = 1'b0;
    sample_in = 14'h0ABC; sample_valid = 1'b1;
    @(negedge clk);
    chk("byp_tick", sample_tick, 1);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(negedge clk);
    chk("byp_current", dut.current, 16'h0ABC);
    chk("byp_hold_full", dut.hold_full, 0);
    chk("byp_count", underrun_count, 0);

    // Starvation saturates the counter; a clear on an underrunning tick wins.
    for (int k = 0; k < 300; k++) tick_wait();
    @(negedge clk);
    chk("und_sat", underrun_count, UMAX);
    goto_div(CLKDIV - 1);
    underrun_clr = 1'b1;
    @(posedge clk); #1;
    underrun_clr = 1'b0;
    @(negedge clk);
    chk("und_clr_on_tick", underrun_count, 0);

    // Asynchronous reset while the hold is full.
    goto_div(4);
    offer(14'h0777);
    @(negedge clk);
    chk("pre_rst_hold_full", dut.hold_full, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_pdm", pdm_out, 0);
    chk("arst_ready", sample_ready, 1);
    chk("arst_count", underrun_count, 0);
    chk("arst_current", dut.current, MID);
    @(posedge clk); #1;
    rst = 1'b0;

    // Disable: no ticks, silent output, divider restarts on re-enable.
    repeat (40) @(posedge clk);
    #1 enable = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("dis_tick", sample_tick, 0);
      if (k > 0) chk("dis_pdm", pdm_out, 0);
    end
    @(posedge clk); #1;
    enable = 1'b1;
    idx = 0;
    @(negedge clk);
    while (!sample_tick && idx < 4 * CLKDIV) begin
      idx++;
      @(negedge clk);
    end
    chk("reen_first_tick", idx, CLKDIV - 1);

    // Random traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      rst          = ($urandom_range(0, 499) == 0);
      enable       = ($urandom_range(0, 19) != 0);
      sample_valid = ($urandom_range(0, 9) < 3);
      sample_in    = BITDEPTH'($urandom);
      underrun_clr = ($urandom_range(0, 63) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; sample_valid = 1'b0; underrun_clr = 1'b0; enable = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
